nand_stim_gen: RTL and testbench
================================

# nand_stim_gen

Synthesizable upstream stimulus stage for the four-input NAND gate block: drives its `a`, `b`, `c`, `d` inputs with four independent square waves of programmable half-period. A start/stop handshake runs one full exhaustive pattern window and then signals completion. It replaces free-running delay-based toggling with clocked counters, so the same pattern can feed the gate in hardware.

## Interface

- `HALF_A`, default 10: half-period of `a`, in clk cycles
- `HALF_B`, default 7: half-period of `b`, in clk cycles
- `HALF_C`, default 5: half-period of `c`, in clk cycles
- `HALF_D`, default 1: half-period of `d`, in clk cycles
- `RUN_LEN`, default 140: run-window length, in clk cycles
- `CNT_W`, default 8: width of every internal counter
- `clk`  input  1  single clock; all state updates on the rising edge
- `rst`  input  1  reset, asynchronous and active-high
- `start`  input  1  level-sampled request to begin a run; honoured only in IDLE
- `stop`  input  1  abort request; honoured in RUN and in IDLE
- `a`, `b`, `c`, `d`  output  1 each  stimulus to the NAND gate block
- `busy`  output  1  high while in RUN
- `done`  output  1  single-cycle pulse, high while in DONE

## Operation

- Parameter legality: each HALF_x ≥ 1, RUN_LEN ≥ 1, and every value < 2^CNT_W. Violations are an elaboration error.
- Reset (async, any state): state=IDLE; all counters = 0; a, b, c, d, busy and done = 0.
- **IDLE**
  - Outputs are 0 and counters are held at 0.
  - start=1 and stop=0 → RUN. Counters are cleared on that same edge.
  - start=1 and stop=1 together → remain IDLE (stop wins).
- **RUN**
  - On every edge, each channel x updates as follows:
    - if cnt_x == HALF_x−1: cnt_x ← 0 and x ← ~x;
    - otherwise: cnt_x ← cnt_x+1.
  - run_cnt increments every edge. When run_cnt == RUN_LEN−1, the next state is DONE; channels still update on that edge.
  - stop=1 → IDLE on the next edge. Outputs and counters are cleared and no done pulse is produced.
  - start is ignored.
- **DONE**
  - done=1 for exactly one cycle, with a..d holding their last values.
  - The next edge returns to IDLE unconditionally, clearing a..d.
  - start and stop are ignored.
- With the default parameters, 140 cycles is the LCM of the full periods (20, 14, 10, 2). Every channel completes an even number of toggles and ends at 0, so every (a,b,c,d) combination is exercised.
- Counters never exceed HALF_x−1 or RUN_LEN−1. No overflow path exists.

## Timing

- start is sampled at edge k → busy=1 after edge k.
- The first toggle of channel x occurs at edge k+HALF_x:
  - d at k+1, c at k+5, b at k+7, a at k+10.
- The last RUN edge is k+RUN_LEN (default k+140). done=1 during the cycle that follows it, and the block is back in IDLE after edge k+RUN_LEN+1.
- Earliest restart: start high during that IDLE cycle is sampled at edge k+RUN_LEN+2.
- stop is sampled at edge m while in RUN → busy=0 and a..d=0 after edge m.
- All outputs are registered. There is no combinational path from input to output.

## Structure

- Package `nand_stim_pkg` holds:
  - the state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default half-period constants for the four channels;
  - the default RUN_LEN.
- Sub-module `toggle_channel`, instantiated four times:
  - parameters HALF and CNT_W;
  - inputs clk, rst, en and clr;
  - output q.
  - It contains the half-period counter and the output flop.
- The top level holds the FSM and run_cnt, and drives en = (state==RUN) and clr = (leaving RUN or DONE toward IDLE).

## Test plan

- **Reset:** assert rst mid-run at cycle 35 → a..d, busy and done = 0 immediately, without waiting for a clock edge. After release the block is in IDLE and a held start is honoured on the next edge.
- **Start cadence (defaults):** pulse start at edge k.
  - d toggles on every edge.
  - c is 1 during cycles k+5 to k+9.
  - b rises at k+7.
  - a rises at k+10 and falls at k+20.
- **Full run:** the 140-cycle window covers all 16 abcd values at least once. done is high for exactly one cycle after edge k+140 with a..d=0, and busy falls at that same edge.
- **Abort:** stop at cycle 35 of a run → outputs 0 on the next cycle, no done pulse. A new start then restarts the pattern from zero, with a rising at +10.
- **Ignored requests:** start pulses during RUN and DONE leave the timing unchanged. start and stop together in IDLE → stays IDLE and busy stays 0.
- **Non-default parameters:** HALF_A=3, HALF_D=2, RUN_LEN=12 → a toggles every 3 cycles, d every 2 cycles, and done asserts after edge k+12.

Source files
------------

// File: rtl/nand_stim_pkg.sv
// Shared state encoding and default timing constants for the NAND stimulus generator.
package nand_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_HALF_A  = 10;
  localparam int DEF_HALF_B  = 7;
  localparam int DEF_HALF_C  = 5;
  localparam int DEF_HALF_D  = 1;
  localparam int DEF_RUN_LEN = 140;

endpackage

// File: rtl/nand_stim_gen_toggle_channel.sv
// One square-wave channel: a half-period counter and the output flop it toggles.
module toggle_channel
  import nand_stim_pkg::*;
#(
  parameter int HALF  = 1,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic q
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             q_r;

  // Half-period counter and output flop; clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
      q_r   <= 1'b0;
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
      q_r   <= 1'b0;
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r <= {CNT_W{1'b0}};
        q_r   <= ~q_r;
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
      q_r   <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/nand_stim_gen.sv
// Four-channel square-wave stimulus for the NAND gate block, gated by a
// start/stop handshake that runs one exhaustive pattern window.
module nand_stim_gen
  import nand_stim_pkg::*;
#(
  parameter int HALF_A  = DEF_HALF_A,
  parameter int HALF_B  = DEF_HALF_B,
  parameter int HALF_C  = DEF_HALF_C,
  parameter int HALF_D  = DEF_HALF_D,
  parameter int RUN_LEN = DEF_RUN_LEN,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic busy,
  output logic done
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (HALF_A < 1 || HALF_A > CNT_MAX || HALF_B < 1 || HALF_B > CNT_MAX ||
      HALF_C < 1 || HALF_C > CNT_MAX || HALF_D < 1 || HALF_D > CNT_MAX ||
      RUN_LEN < 1 || RUN_LEN > CNT_MAX) begin : g_param_err
    $error("nand_stim_gen: half-periods and RUN_LEN must be in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_LEN - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] run_cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             en_s;
  logic             clr_s;

  // Next-state decode; channels are held clear everywhere except an unaborted RUN.
  always_comb begin
    state_next_s = state_r;
    en_s         = 1'b0;
    clr_s        = 1'b1;
    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        en_s = 1'b1;
        if (stop) begin
          state_next_s = IDLE;
        end else begin
          clr_s = 1'b0;
          if (run_cnt_r == RUN_LAST) begin
            state_next_s = DONE;
          end else begin
            state_next_s = RUN;
          end
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, run-window counter and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      run_cnt_r <= {CNT_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
      if (state_r == RUN && state_next_s == RUN) begin
        run_cnt_r <= run_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        run_cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  toggle_channel #(.HALF(HALF_A), .CNT_W(CNT_W)) u_ch_a (
    .clk(clk), .rst(rst), .en(en_s), .clr(clr_s), .q(a)
  );
  toggle_channel #(.HALF(HALF_B), .CNT_W(CNT_W)) u_ch_b (
    .clk(clk), .rst(rst), .en(en_s), .clr(clr_s), .q(b)
  );
  toggle_channel #(.HALF(HALF_C), .CNT_W(CNT_W)) u_ch_c (
    .clk(clk), .rst(rst), .en(en_s), .clr(clr_s), .q(c)
  );
  toggle_channel #(.HALF(HALF_D), .CNT_W(CNT_W)) u_ch_d (
    .clk(clk), .rst(rst), .en(en_s), .clr(clr_s), .q(d)
  );

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_nand_stim_gen.sv
// Randomized self-checking bench: outputs are predicted from the cycle count
// since start as (t / HALF) mod 2, with busy/done derived from the window length.
module tb_nand_stim_gen;

  logic clk = 1'b0;
  logic rst, start, stop, start2, stop2;
  logic a, b, c, d, busy, done;
  logic a2, b2, c2, d2, busy2, done2;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  nand_stim_gen u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done)
  );

  nand_stim_gen #(.HALF_A(3), .HALF_D(2), .RUN_LEN(12)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2)
  );

  // Expected {a,b,c,d,busy,done} t cycles after the start edge (outside the window: idle).
  function automatic logic [5:0] model(int t, int ha, int hb, int hc, int hd, int rl);
    logic [5:0] r;
    r = 6'b0;
    if (t >= 0 && t <= rl) begin
      r[5] = ((t / ha) % 2) == 1;
      r[4] = ((t / hb) % 2) == 1;
      r[3] = ((t / hc) % 2) == 1;
      r[2] = ((t / hd) % 2) == 1;
      r[1] = (t < rl);
      r[0] = (t == rl);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    rst = 1'b1; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({a, b, c, d, busy, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_hold got %b exp %b", {a, b, c, d, busy, done}, 6'b0);
    end
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= 35; t++) begin
      exp = model(t, 10, 7, 5, 1, 140);
      n_tests++;
      if ({a, b, c, d, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL reset_prerun t=%0d got %b exp %b", t, {a, b, c, d, busy, done}, exp);
      end
      if (t < 35) tick();
    end
    // Mid-cycle assertion: no clock edge between here and the check.
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({a, b, c, d, busy, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_async got %b exp %b", {a, b, c, d, busy, done}, 6'b0);
    end
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    exp = model(0, 10, 7, 5, 1, 140);
    n_tests++;
    if ({a, b, c, d, busy, done} !== exp) begin
      n_fail++;
      $display("FAIL reset_restart got %b exp %b", {a, b, c, d, busy, done}, exp);
    end
    start = 1'b0;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
    n_tests++;
    if ({a, b, c, d, busy, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_stop got %b exp %b", {a, b, c, d, busy, done}, 6'b0);
    end
  endtask

  task automatic test_full_run();
    logic [5:0] exp;
    bit         seen [16];
    int         done_cnt = 0;
    int         n_seen   = 0;
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    start = 1'b1;
    tick();
    for (int t = 0; t <= 141; t++) begin
      exp = model(t, 10, 7, 5, 1, 140);
      n_tests++;
      if ({a, b, c, d, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL full_run t=%0d got %b exp %b", t, {a, b, c, d, busy, done}, exp);
      end
      if (busy === 1'b1) seen[{a, b, c, d}] = 1'b1;
      if (done === 1'b1) done_cnt++;
      // Start requests during RUN and DONE must have no effect.
      start = (t <= 140) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (t < 141) tick();
    end
    start = 1'b0;
    for (int i = 0; i < 16; i++) if (seen[i]) n_seen++;
    n_tests++;
    if (n_seen != 16) begin
      n_fail++;
      $display("FAIL full_run_coverage got %0d patterns exp 16", n_seen);
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL full_run_done_pulses got %0d exp 1", done_cnt);
    end
  endtask

  task automatic test_abort(int m);
    logic [5:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= m; t++) begin
      exp = model(t, 10, 7, 5, 1, 140);
      n_tests++;
      if ({a, b, c, d, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL abort_run m=%0d t=%0d got %b exp %b", m, t, {a, b, c, d, busy, done}, exp);
      end
      if (t < m) tick();
    end
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      stop = 1'b0;
      n_tests++;
      if ({a, b, c, d, busy, done} !== 6'b0) begin
        n_fail++;
        $display("FAIL abort_idle m=%0d i=%0d got %b exp %b", m, i, {a, b, c, d, busy, done}, 6'b0);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= 21; t++) begin
      exp = model(t, 10, 7, 5, 1, 140);
      n_tests++;
      if ({a, b, c, d, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL abort_restart t=%0d got %b exp %b", t, {a, b, c, d, busy, done}, exp);
      end
      if (t < 21) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1;
    stop  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({a, b, c, d, busy, done} !== 6'b0) begin
        n_fail++;
        $display("FAIL start_stop_idle i=%0d got %b exp %b", i, {a, b, c, d, busy, done}, 6'b0);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_params();
    logic [5:0] exp;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int t = 0; t <= 14; t++) begin
      exp = model(t, 3, 7, 5, 2, 12);
      n_tests++;
      if ({a2, b2, c2, d2, busy2, done2} !== exp) begin
        n_fail++;
        $display("FAIL params t=%0d got %b exp %b", t, {a2, b2, c2, d2, busy2, done2}, exp);
      end
      start2 = (t <= 12) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (t < 14) tick();
    end
    start2 = 1'b0;
  endtask

  initial begin
    test_reset();
    repeat ($urandom_range(1, 4)) tick();
    test_full_run();
    test_abort(35);
    test_abort($urandom_range(1, 130));
    test_start_stop_idle();
    test_full_run();
    test_params();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
